// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the sram-like two-master arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA
  } arb_state_e;

  typedef enum logic {
    OWNER_INST,
    OWNER_DATA
  } arb_owner_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - combinational winner select; SRAM_ARB_RR_EN selects round-robin over data-first
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
`ifdef SRAM_ARB_RR_EN
  input  arb_owner_e last_grant,
`endif
  output arb_owner_e winner
);

  always_comb begin
    winner = OWNER_INST;
    if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      winner = (last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
      winner = OWNER_DATA;
`endif
    end else if (data_req) begin
      winner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one sram-like port between inst and data masters, one transaction in flight
// Round-robin grant when SRAM_ARB_RR_EN is defined, data-first otherwise.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              inst_req_i,
  input  logic              inst_wr_i,
  input  logic [1:0]        inst_size_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [DATA_W-1:0] inst_wdata_i,
  output logic              inst_addr_ok_o,
  output logic              inst_data_ok_o,
  output logic [DATA_W-1:0] inst_rdata_o,

  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_addr_ok_o,
  output logic              data_data_ok_o,
  output logic [DATA_W-1:0] data_rdata_o,

  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_addr_ok_i,
  input  logic              mem_data_ok_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e state, state_n;
  arb_owner_e owner, owner_n;
  arb_owner_e winner, sel;
  logic       addr_ok, data_ok;
  logic       sel_req, sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARB_RR_EN
  arb_owner_e last_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= OWNER_INST;
    end else if (addr_ok) begin
      last_grant <= sel;
    end
  end

  sram_arb_grant u_grant (
    .inst_req   (inst_req_i),
    .data_req   (data_req_i),
    .last_grant (last_grant),
    .winner     (winner)
  );
`else
  sram_arb_grant u_grant (
    .inst_req (inst_req_i),
    .data_req (data_req_i),
    .winner   (winner)
  );
`endif

  // Winner only matters in IDLE; once granted, the latched owner is locked in.
  assign sel       = (state == IDLE) ? winner : owner;
  assign sel_req   = (sel == OWNER_DATA) ? data_req_i   : inst_req_i;
  assign sel_wr    = (sel == OWNER_DATA) ? data_wr_i    : inst_wr_i;
  assign sel_size  = (sel == OWNER_DATA) ? data_size_i  : inst_size_i;
  assign sel_addr  = (sel == OWNER_DATA) ? data_addr_i  : inst_addr_i;
  assign sel_wdata = (sel == OWNER_DATA) ? data_wdata_i : inst_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= OWNER_INST;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    mem_req_o = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req_i || data_req_i) begin
          mem_req_o = 1'b1;
          addr_ok   = mem_addr_ok_i;
          owner_n   = winner;
          state_n   = mem_addr_ok_i ? WAIT_DATA : REQ;
        end
      end
      REQ: begin
        if (!sel_req) begin
          state_n = IDLE;
        end else begin
          mem_req_o = 1'b1;
          if (mem_addr_ok_i) begin
            addr_ok = 1'b1;
            state_n = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (mem_data_ok_i) begin
          data_ok = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request fields are zero whenever nothing is being forwarded.
  assign mem_wr_o    = mem_req_o & sel_wr;
  assign mem_size_o  = mem_req_o ? sel_size  : '0;
  assign mem_addr_o  = mem_req_o ? sel_addr  : '0;
  assign mem_wdata_o = mem_req_o ? sel_wdata : '0;

  assign inst_addr_ok_o = addr_ok && (sel == OWNER_INST);
  assign data_addr_ok_o = addr_ok && (sel == OWNER_DATA);
  assign inst_data_ok_o = data_ok && (sel == OWNER_INST);
  assign data_data_ok_o = data_ok && (sel == OWNER_DATA);
  assign inst_rdata_o   = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inst_req_i, inst_wr_i, data_req_i, data_wr_i;
  logic [1:0]  inst_size_i, data_size_i, mem_size_o;
  logic [31:0] inst_addr_i, inst_wdata_i, data_addr_i, data_wdata_i;
  logic        inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o;
  logic [31:0] inst_rdata_o, data_rdata_o;
  logic        mem_req_o, mem_wr_o, mem_addr_ok_i, mem_data_ok_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .inst_req_i     (inst_req_i),
    .inst_wr_i      (inst_wr_i),
    .inst_size_i    (inst_size_i),
    .inst_addr_i    (inst_addr_i),
    .inst_wdata_i   (inst_wdata_i),
    .inst_addr_ok_o (inst_addr_ok_o),
    .inst_data_ok_o (inst_data_ok_o),
    .inst_rdata_o   (inst_rdata_o),
    .data_req_i     (data_req_i),
    .data_wr_i      (data_wr_i),
    .data_size_i    (data_size_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_addr_ok_o (data_addr_ok_o),
    .data_data_ok_o (data_data_ok_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_wr_o       (mem_wr_o),
    .mem_size_o     (mem_size_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_addr_ok_i  (mem_addr_ok_i),
    .mem_data_ok_i  (mem_data_ok_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    inst_req_i = 0; inst_wr_i = 0; inst_size_i = SIZE_WORD; inst_addr_i = 0; inst_wdata_i = 0;
    data_req_i = 0; data_wr_i = 0; data_size_i = SIZE_WORD; data_addr_i = 0; data_wdata_i = 0;
    mem_addr_ok_i = 0; mem_data_ok_i = 0; mem_rdata_i = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, {31'b0, mem_req_o}, 32'd0);
    chk({tag, "_mem_wr"}, {31'b0, mem_wr_o}, 32'd0);
    chk({tag, "_mem_size"}, {30'b0, mem_size_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_oks"}, {28'b0, inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o}, 32'd0);
  endtask

  logic [31:0] exp_addr;

  initial begin
    clear_inputs();
    rst_i = 1;
    next_cycle();
    next_cycle();
    rst_i = 0;
    sample();
    chk_quiet("reset");

    // inst-only read; stray data_ok in the addr_ok cycle must be ignored
    next_cycle();
    inst_req_i = 1; inst_addr_i = 32'h1000; mem_addr_ok_i = 1; mem_data_ok_i = 1;
    sample();
    chk("t1_mem_req", {31'b0, mem_req_o}, 32'd1);
    chk("t1_mem_addr", mem_addr_o, 32'h1000);
    chk("t1_mem_size", {30'b0, mem_size_o}, 32'd2);
    chk("t1_inst_addr_ok", {31'b0, inst_addr_ok_o}, 32'd1);
    chk("t1_stray_data_ok", {30'b0, inst_data_ok_o, data_data_ok_o}, 32'd0);
    next_cycle();
    inst_req_i = 0; mem_addr_ok_i = 0; mem_data_ok_i = 1; mem_rdata_i = 32'hDEADBEEF;
    sample();
    chk("t1_inst_data_ok", {31'b0, inst_data_ok_o}, 32'd1);
    chk("t1_inst_rdata", inst_rdata_o, 32'hDEADBEEF);
    chk("t1_data_data_ok", {31'b0, data_data_ok_o}, 32'd0);
    chk("t1_wait_mem_req", {31'b0, mem_req_o}, 32'd0);
    next_cycle();
    mem_data_ok_i = 0;

    // both masters request continuously for 4 transactions
    inst_req_i = 1; inst_addr_i = 32'h1000; data_req_i = 1; data_addr_i = 32'h2000;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      exp_addr = (i % 2 == 0) ? 32'h2000 : 32'h1000;
`else
      exp_addr = 32'h2000;
`endif
      mem_addr_ok_i = 1;
      sample();
      chk($sformatf("t2_addr_%0d", i), mem_addr_o, exp_addr);
      chk($sformatf("t2_addr_ok_%0d", i), {30'b0, inst_addr_ok_o, data_addr_ok_o},
          (exp_addr == 32'h2000) ? 32'd1 : 32'd2);
      next_cycle();
      mem_addr_ok_i = 0; mem_data_ok_i = 1; mem_rdata_i = 32'h100 + i;
      sample();
      chk($sformatf("t2_data_ok_%0d", i), {30'b0, inst_data_ok_o, data_data_ok_o},
          (exp_addr == 32'h2000) ? 32'd1 : 32'd2);
      chk($sformatf("t2_wait_req_%0d", i), {31'b0, mem_req_o}, 32'd0);
      next_cycle();
      mem_data_ok_i = 0;
    end

    // data releases; inst granted in the IDLE cycle after data_ok
    data_req_i = 0; mem_addr_ok_i = 1;
    sample();
    chk("t2_inst_after", mem_addr_o, 32'h1000);
    next_cycle();
    inst_req_i = 0; mem_addr_ok_i = 0; mem_data_ok_i = 1;
    sample();
    chk("t2_inst_after_dok", {31'b0, inst_data_ok_o}, 32'd1);
    next_cycle();
    mem_data_ok_i = 0;

    // data holds req without addr_ok; inst cannot preempt, stray data_ok ignored
    inst_req_i = 1; data_req_i = 1;
    for (int i = 0; i < 3; i++) begin
      mem_data_ok_i = (i == 1);
      sample();
      chk($sformatf("t3_addr_%0d", i), mem_addr_o, 32'h2000);
      chk($sformatf("t3_oks_%0d", i),
          {28'b0, inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o}, 32'd0);
      next_cycle();
    end
    mem_data_ok_i = 0;

    // data flushes in REQ; inst write granted next cycle
    data_req_i = 0;
    sample();
    chk("t4_flush_req", {31'b0, mem_req_o}, 32'd0);
    chk("t4_flush_inst_aok", {31'b0, inst_addr_ok_o}, 32'd0);
    next_cycle();
    inst_wr_i = 1; inst_wdata_i = 32'hCAFEF00D; mem_addr_ok_i = 1;
    sample();
    chk("t4_grant_addr", mem_addr_o, 32'h1000);
    chk("t4_grant_wr", {31'b0, mem_wr_o}, 32'd1);
    chk("t4_grant_wdata", mem_wdata_o, 32'hCAFEF00D);
    chk("t4_grant_aok", {31'b0, inst_addr_ok_o}, 32'd1);
    next_cycle();

    // reset while waiting for data; late data_ok is dropped
    clear_inputs();
    rst_i = 1;
    next_cycle();
    rst_i = 0;
    mem_data_ok_i = 1; mem_rdata_i = 32'h12345678;
    sample();
    chk_quiet("t5_post_reset");
    next_cycle();
    clear_inputs();
    sample();
    chk_quiet("t5_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
